note_track_judge: RTL and testbench



---
 rtl/note_track_judge.sv | 183 ++++++++++++++++++
 tb/tb_note_track_judge.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_track_judge.sv
// note_track_judge
//   One falling note row for the rhythm game. A row of up to LANES notes
//   moves down the screen one STEP_PX step every STEP_DIV clocks. The module
//   drives per-lane sprite enables for the pixel mux and judges key presses
//   against a hit window on the note centre row. It emits one-cycle
//   hit/miss/wrap pulses and keeps a saturating score and streak.
// Ports
//   CLOCK_25       in   pixel/system clock
//   reset          in   synchronous, active-high
//   start          in   1-cycle pulse: load command_in/y_ini_pos, begin falling
//   pause          in   freeze step counter and y_pos (judging stays live)
//   command_in     in   next note pattern, bit i = lane i has a note
//   y_ini_pos      in   start row used by start/reset
//   keys           in   synchronised key levels, 1 = pressed
//   next_x/next_y  in   pixel coordinate being drawn
//   command_out    out  latched active pattern
//   y_pos          out  note centre row
//   sprite_pattern out  lane pixel enables for next_x/next_y
//   hit_pulse      out  correct press inside the window
//   miss_pulse     out  wrong press, or note left the window unjudged
//   wrap_pulse     out  note wrapped to the top; new pattern latched
//   score          out  hit count, saturating
//   streak         out  consecutive hits, saturating, cleared by a miss
module note_track_judge #(
  parameter int LANES     = 4,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int NOTE_H    = 32,
  parameter int STEP_DIV  = 800000,
  parameter int STEP_PX   = 1,
  parameter int HIT_Y_MIN = 412,
  parameter int HIT_Y_MAX = 460,
  parameter int SCORE_W   = 16
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic [LANES-1:0]   command_in,
  input  logic [9:0]         y_ini_pos,
  input  logic [LANES-1:0]   keys,
  input  logic [9:0]         next_x,
  input  logic [9:0]         next_y,
  output logic [LANES-1:0]   command_out,
  output logic [9:0]         y_pos,
  output logic [LANES-1:0]   sprite_pattern,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               wrap_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] streak
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int LANE_W = SCREEN_W / LANES;
  localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [9:0] L_SCREEN_H = 10'(SCREEN_H);
  localparam logic [9:0] L_STEP_PX  = 10'(STEP_PX);
  localparam logic [9:0] L_HIT_MIN  = 10'(HIT_Y_MIN);
  localparam logic [9:0] L_HIT_MAX  = 10'(HIT_Y_MAX);
  localparam logic [10:0] L_HALF    = 11'(NOTE_H / 2);

  typedef enum logic {S_IDLE = 1'b0, S_FALL = 1'b1} state_t;

  state_t r_state, w_state_next;

  logic [CNT_W-1:0]   r_cnt;
  logic [9:0]         r_y;
  logic [LANES-1:0]   r_cmd;
  logic               r_judged;
  logic               r_hidden;
  logic [LANES-1:0]   r_keys_q;
  logic               r_hit, r_miss, r_wrap;
  logic [SCORE_W-1:0] r_score, r_streak;

  logic       w_fall, w_step, w_wrap, w_in_win, w_armed, w_attempt, w_match, w_exit;
  logic       w_hit, w_miss;
  logic [9:0] w_y_inc;
  logic [10:0] w_x11, w_ny11, w_y11;
  logic       w_y_ok;
  logic [LANES-1:0] w_sprite;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge CLOCK_25) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // IDLE leaves only on start; FALL is left only through reset.
  always_comb begin
    w_state_next = r_state;
    if (r_state == S_IDLE && start) w_state_next = S_FALL;
  end

  // A start in the same cycle takes precedence: it reloads the row, so the
  // step timer and the judge are both held off for that cycle.
  assign w_fall    = (r_state == S_FALL);
  assign w_step    = w_fall && !start && !pause && (r_cnt == L_CNT_LAST);
  assign w_wrap    = w_step && (r_y >= L_SCREEN_H);
  assign w_y_inc   = r_y + L_STEP_PX;
  assign w_in_win  = (r_y >= L_HIT_MIN) && (r_y <= L_HIT_MAX);
  assign w_armed   = w_fall && !start && !r_judged && (r_cmd != '0);
  assign w_attempt = w_armed && w_in_win && (|(keys & ~r_keys_q));
  assign w_match   = (keys == r_cmd);
  // Window-exit miss is suppressed when an attempt judges the note this cycle.
  assign w_exit    = w_armed && !w_attempt && w_step && !w_wrap &&
                     (r_y <= L_HIT_MAX) && (w_y_inc > L_HIT_MAX);
  assign w_hit     = w_attempt && w_match;
  assign w_miss    = (w_attempt && !w_match) || w_exit;

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_cnt    <= '0;
      r_y      <= y_ini_pos;
      r_cmd    <= '0;
      r_judged <= 1'b0;
      r_hidden <= 1'b0;
      r_keys_q <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_wrap   <= 1'b0;
      r_score  <= '0;
      r_streak <= '0;
    end else begin
      r_keys_q <= keys;
      r_hit    <= w_hit;
      r_miss   <= w_miss;
      r_wrap   <= w_wrap;
      if (start) begin
        r_cnt    <= '0;
        r_y      <= y_ini_pos;
        r_cmd    <= command_in;
        r_judged <= 1'b0;
        r_hidden <= 1'b0;
      end else if (w_fall) begin
        if (!pause) r_cnt <= w_step ? '0 : r_cnt + 1'b1;
        if (w_wrap) begin
          r_y      <= '0;
          r_cmd    <= command_in;
          r_judged <= 1'b0;
          r_hidden <= 1'b0;
        end else begin
          if (w_step) r_y <= w_y_inc;
          if (w_attempt || w_exit) r_judged <= 1'b1;
          if (w_hit) r_hidden <= 1'b1;
        end
      end
      if (w_hit) begin
        r_score  <= sat_inc(r_score);
        r_streak <= sat_inc(r_streak);
      end else if (w_miss) begin
        r_streak <= '0;
      end
    end
  end

  // Vertical test in 11 bits so rows near the top never underflow.
  assign w_x11  = {1'b0, next_x};
  assign w_ny11 = {1'b0, next_y};
  assign w_y11  = {1'b0, r_y};
  assign w_y_ok = ((w_ny11 + L_HALF) >= w_y11) && (w_ny11 < (w_y11 + L_HALF));

  always_comb begin
    w_sprite = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sprite[i] = w_fall && r_cmd[i] && !r_hidden && w_y_ok &&
                    (w_x11 >= 11'(i * LANE_W)) && (w_x11 < 11'((i + 1) * LANE_W));
    end
  end

  assign command_out    = r_cmd;
  assign y_pos          = r_y;
  assign sprite_pattern = w_sprite;
  assign hit_pulse      = r_hit;
  assign miss_pulse     = r_miss;
  assign wrap_pulse     = r_wrap;
  assign score          = r_score;
  assign streak         = r_streak;

endmodule

// File: tb/tb_note_track_judge.sv
// Testbench for note_track_judge: directed scenarios plus a randomized run,
// all checked against a behavioural model of the falling note kept here.
module tb_note_track_judge;

  localparam int LANES = 4;
  localparam int SW    = 640;
  localparam int SH    = 480;
  localparam int NH    = 32;
  localparam int SD    = 4;
  localparam int SP    = 1;
  localparam int HMIN  = 412;
  localparam int HMAX  = 460;
  localparam int SCW   = 4;
  localparam int SMAX  = (1 << SCW) - 1;
  localparam int VW    = LANES + 10 + 3 + 2 * SCW;

  logic             CLOCK_25 = 1'b0;
  logic             reset, start, pause;
  logic [LANES-1:0] command_in, keys;
  logic [9:0]       y_ini_pos, next_x, next_y;
  logic [LANES-1:0] command_out, sprite_pattern;
  logic [9:0]       y_pos;
  logic             hit_pulse, miss_pulse, wrap_pulse;
  logic [SCW-1:0]   score, streak;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  bit               m_fall, m_judged, m_hidden, m_hit, m_miss, m_wrap;
  int               m_y, m_cnt, m_score, m_streak;
  logic [LANES-1:0] m_cmd, m_kq;

  note_track_judge #(
    .LANES(LANES), .SCREEN_W(SW), .SCREEN_H(SH), .NOTE_H(NH), .STEP_DIV(SD),
    .STEP_PX(SP), .HIT_Y_MIN(HMIN), .HIT_Y_MAX(HMAX), .SCORE_W(SCW)
  ) dut (
    .CLOCK_25(CLOCK_25), .reset(reset), .start(start), .pause(pause),
    .command_in(command_in), .y_ini_pos(y_ini_pos), .keys(keys),
    .next_x(next_x), .next_y(next_y), .command_out(command_out),
    .y_pos(y_pos), .sprite_pattern(sprite_pattern), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .wrap_pulse(wrap_pulse), .score(score),
    .streak(streak)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  function automatic logic [LANES-1:0] m_sprite(input int x, input int y);
    logic [LANES-1:0] s;
    s = '0;
    for (int i = 0; i < LANES; i++)
      s[i] = m_fall && m_cmd[i] && !m_hidden &&
             x >= i * SW / LANES && x < (i + 1) * SW / LANES &&
             y + NH / 2 >= m_y && y < m_y + NH / 2;
    return s;
  endfunction

  function automatic int sat(input int v);
    return (v < SMAX) ? v + 1 : SMAX;
  endfunction

  // Advance the model with the inputs currently applied, then clock the DUT
  // and settle 1 time unit after the edge.
  task automatic tick();
    bit kedge, att;
    int oldy;
    if (reset) begin
      m_fall = 0; m_y = y_ini_pos; m_cmd = '0; m_cnt = 0; m_judged = 0;
      m_hidden = 0; m_kq = '0; m_hit = 0; m_miss = 0; m_wrap = 0;
      m_score = 0; m_streak = 0;
    end else begin
      m_hit = 0; m_miss = 0; m_wrap = 0;
      kedge = (keys & ~m_kq) != '0;
      m_kq = keys;
      if (start) begin
        m_fall = 1; m_y = y_ini_pos; m_cmd = command_in; m_cnt = 0;
        m_judged = 0; m_hidden = 0;
      end else if (m_fall) begin
        att = !m_judged && m_cmd != '0 && m_y >= HMIN && m_y <= HMAX && kedge;
        if (att) begin
          m_judged = 1;
          if (keys == m_cmd) begin
            m_hit = 1; m_hidden = 1; m_score = sat(m_score); m_streak = sat(m_streak);
          end else begin
            m_miss = 1; m_streak = 0;
          end
        end
        if (!pause) begin
          if (m_cnt == SD - 1) begin
            m_cnt = 0;
            if (m_y >= SH) begin
              m_y = 0; m_cmd = command_in; m_judged = 0; m_hidden = 0; m_wrap = 1;
            end else begin
              oldy = m_y;
              m_y = m_y + SP;
              if (oldy <= HMAX && m_y > HMAX && !m_judged && m_cmd != '0) begin
                m_miss = 1; m_streak = 0; m_judged = 1;
              end
            end
          end else begin
            m_cnt++;
          end
        end
      end
    end
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic do_reset(input int yi);
    reset = 1; start = 0; pause = 0; keys = '0; command_in = '0;
    y_ini_pos = 10'(yi);
    tick();
    reset = 0;
  endtask

  task automatic begin_note(input logic [LANES-1:0] cmd, input int yi);
    command_in = cmd; y_ini_pos = 10'(yi); start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    reset = 1; start = 1; pause = 1; keys = 4'b1111; command_in = 4'b1010;
    y_ini_pos = 10'd100; next_x = 10'd10; next_y = 10'd100;
    tick(); tick();
    reset = 0; start = 0; pause = 0; keys = '0;
    checks++; if (y_pos !== 10'd100) begin failures++; $display("FAIL reset_y_pos got=%0d exp=100", y_pos); end
    checks++; if (command_out !== 4'b0000) begin failures++; $display("FAIL reset_cmd got=%b exp=0000", command_out); end
    checks++; if ({hit_pulse, miss_pulse, wrap_pulse} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {hit_pulse, miss_pulse, wrap_pulse}); end
    checks++; if (score !== '0 || streak !== '0) begin failures++; $display("FAIL reset_score got=%0d/%0d exp=0/0", score, streak); end
    checks++; if (sprite_pattern !== 4'b0000) begin failures++; $display("FAIL reset_sprite got=%b exp=0000", sprite_pattern); end
  endtask

  task automatic test_fall_sprite();
    do_reset(100);
    begin_note(4'b0101, 100);
    repeat (40) tick();
    checks++; if (y_pos !== 10'd110) begin failures++; $display("FAIL fall_y_pos got=%0d exp=110", y_pos); end
    checks++; if (command_out !== 4'b0101) begin failures++; $display("FAIL fall_cmd got=%b exp=0101", command_out); end
    next_x = 10'd10; next_y = 10'd110; #1;
    checks++; if (sprite_pattern !== 4'b0001) begin failures++; $display("FAIL sprite_lane0 got=%b exp=0001", sprite_pattern); end
    next_x = 10'd200; next_y = 10'd110; #1;
    checks++; if (sprite_pattern !== 4'b0000) begin failures++; $display("FAIL sprite_lane1 got=%b exp=0000", sprite_pattern); end
    next_x = 10'd10; next_y = 10'd126; #1;
    checks++; if (sprite_pattern !== 4'b0000) begin failures++; $display("FAIL sprite_below got=%b exp=0000", sprite_pattern); end
    next_x = 10'd330; next_y = 10'd94; #1;
    checks++; if (sprite_pattern !== 4'b0100) begin failures++; $display("FAIL sprite_lane2_top got=%b exp=0100", sprite_pattern); end
  endtask

  task automatic test_hit();
    do_reset(0);
    begin_note(4'b0101, 430);
    keys = 4'b0101;
    tick();
    checks++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0) begin failures++; $display("FAIL hit_pulse got=%b%b exp=10", hit_pulse, miss_pulse); end
    checks++; if (score !== 4'd1 || streak !== 4'd1) begin failures++; $display("FAIL hit_score got=%0d/%0d exp=1/1", score, streak); end
    next_x = 10'd10; next_y = y_pos; #1;
    checks++; if (sprite_pattern !== 4'b0000) begin failures++; $display("FAIL hit_hidden got=%b exp=0000", sprite_pattern); end
    tick();
    checks++; if (hit_pulse !== 1'b0) begin failures++; $display("FAIL hit_one_cycle got=%b exp=0", hit_pulse); end
    keys = '0; tick();
    keys = 4'b0101; tick();
    checks++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || score !== 4'd1) begin failures++; $display("FAIL second_press got=%b%b score=%0d exp=00 score=1", hit_pulse, miss_pulse, score); end
    keys = '0; tick();
  endtask

  task automatic test_miss();
    do_reset(0);
    begin_note(4'b0101, 430);
    keys = 4'b0101; tick(); keys = '0; tick();
    begin_note(4'b0101, 430);
    keys = 4'b0100;
    tick();
    checks++; if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0) begin failures++; $display("FAIL wrong_key_pulse got=%b%b exp=01", hit_pulse, miss_pulse); end
    checks++; if (streak !== 4'd0 || score !== 4'd1) begin failures++; $display("FAIL wrong_key_score got=%0d/%0d exp=1/0", score, streak); end
    keys = '0; tick();
  endtask

  task automatic test_exit_wrap();
    int n;
    bit seen;
    logic [9:0] prev_y;
    do_reset(0);
    begin_note(4'b0011, 455);
    command_in = 4'b1000;
    seen = 0; n = 0;
    while (!seen && n < 200) begin
      tick(); n++;
      if (miss_pulse === 1'b1) seen = 1;
    end
    checks++; if (!seen || y_pos !== 10'd461) begin failures++; $display("FAIL exit_miss seen=%0d y_pos=%0d exp seen=1 y_pos=461", seen, y_pos); end
    seen = 0; n = 0; prev_y = y_pos;
    while (!seen && n < 200) begin
      prev_y = y_pos;
      tick(); n++;
      if (wrap_pulse === 1'b1) seen = 1;
    end
    checks++; if (!seen || y_pos !== 10'd0 || prev_y !== 10'd480) begin failures++; $display("FAIL wrap seen=%0d y_pos=%0d prev=%0d exp seen=1 y_pos=0 prev=480", seen, y_pos, prev_y); end
    checks++; if (command_out !== 4'b1000) begin failures++; $display("FAIL wrap_cmd got=%b exp=1000", command_out); end
    tick();
    checks++; if (wrap_pulse !== 1'b0) begin failures++; $display("FAIL wrap_one_cycle got=%b exp=0", wrap_pulse); end
  endtask

  task automatic test_pause_reset();
    logic [9:0] yf;
    do_reset(0);
    begin_note(4'b0001, 430);
    keys = 4'b0001; tick(); keys = '0; tick();
    begin_note(4'b0001, 298);
    repeat (5) tick();
    yf = y_pos;
    pause = 1;
    repeat (20) tick();
    checks++; if (y_pos !== yf || y_pos !== 10'(m_y)) begin failures++; $display("FAIL pause_freeze got=%0d exp=%0d", y_pos, yf); end
    pause = 0;
    repeat (6) tick();
    checks++; if (y_pos !== 10'(m_y)) begin failures++; $display("FAIL pause_resume got=%0d exp=%0d", y_pos, m_y); end
    y_ini_pos = 10'd200; reset = 1;
    tick();
    reset = 0;
    checks++; if (y_pos !== 10'd200 || score !== 4'd0 || command_out !== 4'b0000) begin failures++; $display("FAIL midfall_reset y=%0d score=%0d cmd=%b exp y=200 score=0 cmd=0000", y_pos, score, command_out); end
    keys = 4'b0001; pause = 1;
    repeat (10) tick();
    keys = '0; pause = 0;
    next_x = 10'd10; next_y = 10'd200; #1;
    checks++; if (y_pos !== 10'd200 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || sprite_pattern !== 4'b0000) begin failures++; $display("FAIL idle_hold y=%0d hm=%b%b spr=%b exp y=200 hm=00 spr=0000", y_pos, hit_pulse, miss_pulse, sprite_pattern); end
  endtask

  task automatic test_coincident();
    int n;
    do_reset(0);
    begin_note(4'b0110, 460);
    n = 0;
    while (m_cnt != SD - 1 && n < 20) begin tick(); n++; end
    keys = 4'b0110;
    tick();
    checks++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || y_pos !== 10'd461) begin failures++; $display("FAIL coincident hm=%b%b y=%0d exp hm=10 y=461", hit_pulse, miss_pulse, y_pos); end
    repeat (8) begin
      tick();
      checks++; if (miss_pulse !== 1'b0) begin failures++; $display("FAIL coincident_late_miss got=%b exp=0", miss_pulse); end
    end
    keys = '0;
  endtask

  task automatic test_saturate();
    do_reset(0);
    for (int i = 0; i < SMAX + 3; i++) begin
      keys = '0;
      begin_note(4'b1111, 430);
      keys = 4'b1111;
      tick();
      checks++; if (hit_pulse !== 1'b1) begin failures++; $display("FAIL sat_hit%0d got=%b exp=1", i, hit_pulse); end
    end
    keys = '0;
    checks++; if (score !== 4'hF || streak !== 4'hF) begin failures++; $display("FAIL saturate got=%0d/%0d exp=15/15", score, streak); end
  endtask

  task automatic test_random();
    logic [VW-1:0] exp_v, act_v;
    int ny;
    do_reset($urandom_range(470, 380));
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(499) == 0);
      start = ($urandom_range(49) == 0);
      command_in = LANES'($urandom);
      y_ini_pos = ($urandom_range(9) == 0) ? 10'($urandom_range(490, 470)) : 10'($urandom_range(470, 380));
      pause = ($urandom_range(7) == 0);
      if ($urandom_range(5) == 0) keys = ($urandom_range(2) == 0) ? m_cmd : LANES'($urandom);
      next_x = 10'($urandom_range(SW - 1));
      ny = m_y - 20 + int'($urandom_range(40));
      if (ny < 0) ny = 0;
      next_y = 10'(ny);
      tick();
      exp_v = {m_cmd, 10'(m_y), m_hit, m_miss, m_wrap, SCW'(m_score), SCW'(m_streak)};
      act_v = {command_out, y_pos, hit_pulse, miss_pulse, wrap_pulse, score, streak};
      checks++; if (act_v !== exp_v) begin failures++; $display("FAIL rand_state cyc=%0d got=%h exp=%h", c, act_v, exp_v); end
      checks++; if (sprite_pattern !== m_sprite(next_x, next_y)) begin failures++; $display("FAIL rand_sprite cyc=%0d got=%b exp=%b", c, sprite_pattern, m_sprite(next_x, next_y)); end
    end
    reset = 0; start = 0; pause = 0; keys = '0;
  endtask

  initial begin
    reset = 1; start = 0; pause = 0; keys = '0; command_in = '0;
    y_ini_pos = '0; next_x = '0; next_y = '0;
    test_reset();
    test_fall_sprite();
    test_hit();
    test_miss();
    test_exit_wrap();
    test_pause_reset();
    test_coincident();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
